// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main control FSM: opcode decode, datapath sequencing and memory-wait watchdog.
// Optional jump support is built when MIPS_CTRL_JUMP_EN is defined.
module mips_multicycle_control #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       IorD,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       PCWrite,
  output logic       Branch,
  output logic       PCEn,
  output logic [3:0] state,
  output logic       illegal_op,
  output logic       mem_err
);

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`ifdef MIPS_CTRL_JUMP_EN
  localparam logic [5:0] OP_J     = 6'b000010;
`endif

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEX   = 4'd9,
`ifdef MIPS_CTRL_JUMP_EN
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
`else
    ADDIWB   = 4'd10
`endif
  } state_t;

  state_t           cur_state;
  state_t           nxt_state;
  logic             mem_wait;
  logic [CNT_W-1:0] wait_cnt;

  assign state = cur_state;

  // State register and memory-wait watchdog
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state <= FETCH;
      wait_cnt  <= '0;
      mem_err   <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      if (mem_wait && !mem_ready) begin
        if (wait_cnt < CNT_W'(MEM_TIMEOUT))
          wait_cnt <= wait_cnt + CNT_W'(1);
        if (wait_cnt >= CNT_W'(MEM_TIMEOUT - 1))
          mem_err <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  // Next-state and Moore output decode
  always_comb begin
    nxt_state  = FETCH;
    mem_wait   = 1'b0;
    IorD       = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    PCSrc      = 2'b00;
    IRWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    PCWrite    = 1'b0;
    Branch     = 1'b0;
    illegal_op = 1'b0;

    case (cur_state)
      FETCH: begin
        mem_wait  = 1'b1;
        ALUSrcB   = 2'b01;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        nxt_state = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (Op)
          OP_LW, OP_SW: nxt_state = MEMADR;
          OP_RTYPE:     nxt_state = EXECUTE;
          OP_BEQ:       nxt_state = BRANCH;
          OP_ADDI:      nxt_state = ADDIEX;
`ifdef MIPS_CTRL_JUMP_EN
          OP_J:         nxt_state = JUMP;
`endif
          default: begin
            illegal_op = 1'b1;
            nxt_state  = FETCH;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        if (Op == OP_LW)
          nxt_state = MEMREAD;
        else if (Op == OP_SW)
          nxt_state = MEMWRITE;
        else
          nxt_state = FETCH;
      end
      MEMREAD: begin
        mem_wait  = 1'b1;
        IorD      = 1'b1;
        nxt_state = mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      MEMWRITE: begin
        mem_wait  = 1'b1;
        IorD      = 1'b1;
        MemWrite  = 1'b1;
        nxt_state = mem_ready ? FETCH : MEMWRITE;
      end
      EXECUTE: begin
        ALUSrcA   = 1'b1;
        ALUOp     = 2'b10;
        nxt_state = ALUWB;
      end
      ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b01;
        PCSrc   = 2'b01;
        Branch  = 1'b1;
      end
      ADDIEX: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        nxt_state = ADDIWB;
      end
      ADDIWB: begin
        RegWrite = 1'b1;
      end
`ifdef MIPS_CTRL_JUMP_EN
      JUMP: begin
        PCSrc   = 2'b10;
        PCWrite = 1'b1;
      end
`endif
      default: nxt_state = FETCH;
    endcase

    // Reset abandons the instruction: no write enables or pulses escape
    if (reset) begin
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      MemWrite   = 1'b0;
      RegWrite   = 1'b0;
      Branch     = 1'b0;
      illegal_op = 1'b0;
    end
  end

  assign PCEn = PCWrite | (Branch & Zero);

endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Main control unit for the multicycle MIPS datapath: a Moore state machine that decodes the 6-bit opcode and sequences fetch, decode, execute, memory and writeback. It sits directly upstream of the ALU control decoder, which consumes `ALUOp`. It also drives the select lines of the datapath muxes (ALU source muxes, PC source mux) and the PC, IR, register-file and memory write enables. Memory accesses use a ready handshake with a bounded-wait watchdog.

## Interface
- `MEM_TIMEOUT`, 16: consecutive un-ready wait cycles in a memory state before `mem_err` sets (≥1).
- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `Op`  in  6  instruction opcode, `Instr[31:26]`, taken from the instruction register.
- `Zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `IorD`, `RegDst`, `MemtoReg`, `ALUSrcA`  out  1 each  datapath mux selects.
- `ALUSrcB`  out  2  ALU B source: 00 reg, 01 const 4, 10 SignImm, 11 SignImm<<2.
- `ALUOp`  out  2  to ALU control: 00 add, 01 sub, 10 funct.
- `PCSrc`  out  2  00 ALUResult, 01 ALUOut, 10 jump target.
- `IRWrite`, `MemWrite`, `RegWrite`, `PCWrite`, `Branch`  out  1 each  enables.
- `PCEn`  out  1  `PCWrite | (Branch & Zero)`; combinational on `Zero`.
- `state`  out  4  current state encoding, for debug.
- `illegal_op`  out  1  one-cycle pulse for an unsupported opcode.
- `mem_err`  out  1  sticky watchdog flag.

## Operation
- Opcodes: lw 100011, sw 101011, R-type 000000, beq 000100, addi 001000, j 000010.
- State encodings and the outputs each state drives. Any output not listed for a state is 0.
  - FETCH=0: `ALUSrcB`=01; `IRWrite` and `PCWrite` = `mem_ready`.
  - DECODE=1: `ALUSrcB`=11.
  - MEMADR=2: `ALUSrcA`=1, `ALUSrcB`=10.
  - MEMREAD=3: `IorD`=1.
  - MEMWB=4: `MemtoReg`=1, `RegWrite`=1.
  - MEMWRITE=5: `IorD`=1, `MemWrite`=1.
  - EXECUTE=6: `ALUSrcA`=1, `ALUOp`=10.
  - ALUWB=7: `RegDst`=1, `RegWrite`=1.
  - BRANCH=8: `ALUSrcA`=1, `ALUOp`=01, `PCSrc`=01, `Branch`=1.
  - ADDIEX=9: `ALUSrcA`=1, `ALUSrcB`=10.
  - ADDIWB=10: `RegWrite`=1.
  - JUMP=11: `PCSrc`=10, `PCWrite`=1.
- Transitions:
  - FETCH→DECODE when `mem_ready`; otherwise FETCH holds.
  - DECODE dispatches on `Op`: lw/sw→MEMADR, R-type→EXECUTE, beq→BRANCH, addi→ADDIEX, j→JUMP.
  - MEMADR→MEMREAD for lw, →MEMWRITE for sw.
  - MEMREAD→MEMWB when `mem_ready`; otherwise MEMREAD holds.
  - MEMWRITE→FETCH when `mem_ready`; otherwise holds with `MemWrite` kept at 1.
  - EXECUTE→ALUWB; ADDIEX→ADDIWB.
  - MEMWB, ALUWB, ADDIWB, BRANCH and JUMP all go to FETCH.
- Illegal opcode in DECODE: `illegal_op`=1 for that cycle, next state FETCH, no write enables asserted.
- Encodings 12–15 are unreachable; if entered, next state is FETCH and all enables are 0.
- Watchdog:
  - A counter increments on each cycle spent in FETCH, MEMREAD or MEMWRITE with `mem_ready`=0.
  - It clears on leaving the wait state or on `mem_ready`=1.
  - When the counter reaches `MEM_TIMEOUT`, `mem_err` sets and stays set until `reset`. The counter saturates and the FSM keeps waiting.

## Timing
- `reset` high at a rising edge: `state`←FETCH, watchdog counter←0, `mem_err`←0, `illegal_op`←0.
- While `reset` is high, `IRWrite`, `PCWrite`, `PCEn`, `MemWrite` and `RegWrite` are forced to 0.
- `reset` asserted mid-instruction abandons the instruction. There is no partial writeback after that edge.
- All outputs except `PCEn`, `IRWrite` and the FETCH `PCWrite` are registered-state decodes (Moore).
- Cycle counts with zero memory wait: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Each cycle of memory wait adds one cycle to the count.
- `Op` is sampled only in DECODE and MEMADR; it must stay stable from IR load until the next FETCH.

## Configuration
- `MIPS_CTRL_JUMP_EN` defined: opcode 000010 dispatches DECODE→JUMP.
- `MIPS_CTRL_JUMP_EN` undefined:
  - The JUMP state is not built.
  - Opcode 000010 is treated as illegal: `illegal_op` pulses and the FSM returns to FETCH.
  - `PCSrc`=10 is never driven.

## Test plan
- Reset, then `mem_ready`=1 throughout, `Op`=100011 (lw):
  - `state` sequence 0,2,3,4 appears as 0,1,2,3,4 then 0, i.e. five cycles through FETCH, DECODE, MEMADR, MEMREAD, MEMWB.
  - `RegWrite`=1 and `MemtoReg`=1 only in MEMWB.
  - `PCWrite`=`IRWrite`=1 only in FETCH.
- `Op`=000100 (beq):
  - with `Zero`=1: `PCEn`=1 in BRANCH, `ALUOp`=01, `PCSrc`=01.
  - repeat with `Zero`=0: `PCEn`=0 in BRANCH.
- `Op`=000000 with `mem_ready` low for 3 cycles in FETCH:
  - FETCH held 4 cycles with `IRWrite`=0 until `mem_ready` rises.
  - Then `state` goes 1,6,7 with `ALUOp`=10 in EXECUTE and `RegDst`=1 in ALUWB.
- `Op`=101011 (sw), `mem_ready`=0 for 16 cycles in MEMWRITE:
  - `MemWrite` held at 1 throughout.
  - `mem_err` rises after the 16th wait cycle and stays 1 after `mem_ready` returns, until `reset`.
- `Op`=111111: `illegal_op` pulses 1 cycle in DECODE; next state 0; no write enable asserted.
- `Op`=000010 (j):
  - with `MIPS_CTRL_JUMP_EN`: `state` 0,1,11,0 with `PCWrite`=1 and `PCSrc`=10 in state 11.
  - without the macro: `illegal_op` pulses in DECODE.
- Additionally, assert `reset` during MEMREAD: next state FETCH and `RegWrite` never asserted for that instruction.
